// File: rtl/aes_ctr_xor_stream_pkg.sv
// Shared types and constants for the AES-CTR pad consumer.
// Holds the FSM state encoding and the block-counter helper used by the stream XOR stage.
package aes_ctr_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HAVE
    } state_t;

    localparam int AES_BLOCK_W          = 128;
    localparam int BLOCKS_PER_BEAT_DFLT = 4;
    localparam int NONCE_W              = 96;
    localparam int CTR_W                = 32;

    // Counter advance with the carry kept in the top bit so wrap can be flagged.
    function automatic logic [CTR_W:0] ctr_advance(input logic [CTR_W-1:0] ctr,
                                                   input int unsigned      inc);
        return {1'b0, ctr} + (CTR_W+1)'(inc);
    endfunction

endpackage

// File: rtl/aes_ctr_xor_stream.sv
// AES-CTR pad consumer: requests one pad burst per beat from the pad generator,
// XORs it into the data stream and advances the block counter.
module aes_ctr_xor_stream
    import aes_ctr_pkg::*;
#(
    parameter int DATA_WIDTH      = 512,
    parameter int BLOCKS_PER_BEAT = BLOCKS_PER_BEAT_DFLT
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic [NONCE_W-1:0]    cfg_nonce,
    input  logic [CTR_W-1:0]      cfg_counter,
    input  logic                  cfg_load,
    output logic                  cfg_busy,
    output logic                  err_cfg,
    output logic                  err_wrap,

    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_last,
    input  logic                  in_val,
    output logic                  in_rdy,

    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  out_val,
    input  logic                  out_rdy,

    output logic [NONCE_W-1:0]    pad_req_nonce,
    output logic [CTR_W-1:0]      pad_req_counter,
    output logic                  pad_req_val,
    input  logic                  pad_req_rdy,

    input  logic [DATA_WIDTH-1:0] pad,
    input  logic                  pad_val,
    output logic                  pad_rdy
);

    state_t                  state, state_nxt;
    logic [NONCE_W-1:0]      nonce_q;
    logic [CTR_W-1:0]        ctr_q;
    logic [CTR_W:0]          ctr_sum;
    logic [DATA_WIDTH-1:0]   pad_buf;
    logic                    beat_fire;
    logic                    pad_fire;
    logic                    cfg_accept;

    assign ctr_sum         = ctr_advance(ctr_q, BLOCKS_PER_BEAT);
    assign beat_fire       = in_val & in_rdy;
    assign pad_fire        = pad_val & pad_rdy;
    assign cfg_accept      = cfg_load & (state == S_IDLE);
    assign cfg_busy        = (state != S_IDLE);
    assign pad_req_nonce   = nonce_q;
    assign pad_req_counter = ctr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        pad_req_val = 1'b0;
        pad_rdy     = 1'b0;
        in_rdy      = 1'b0;
        case (state)
            S_IDLE: begin
                if (cfg_load) state_nxt = S_REQ;
            end
            S_REQ: begin
                // Request stays asserted, with stable nonce/counter, until taken.
                pad_req_val = 1'b1;
                if (pad_req_rdy) state_nxt = S_WAIT;
            end
            S_WAIT: begin
                pad_rdy = 1'b1;
                if (pad_val) state_nxt = S_HAVE;
            end
            S_HAVE: begin
                in_rdy = !out_val || out_rdy;
                if (in_val && in_rdy) state_nxt = in_last ? S_IDLE : S_REQ;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Session context and sticky error flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nonce_q  <= '0;
            ctr_q    <= '0;
            err_cfg  <= 1'b0;
            err_wrap <= 1'b0;
        end else begin
            if (cfg_accept) begin
                nonce_q <= cfg_nonce;
                ctr_q   <= cfg_counter;
            end
            if (cfg_load && cfg_busy) err_cfg <= 1'b1;
            if (beat_fire) begin
                ctr_q <= ctr_sum[CTR_W-1:0];
                if (ctr_sum[CTR_W]) err_wrap <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        pad_buf <= '0;
        else if (pad_fire) pad_buf <= pad;
    end

    // Single output register; push and pop in one cycle keeps it full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data <= '0;
            out_last <= 1'b0;
            out_val  <= 1'b0;
        end else if (beat_fire) begin
            out_data <= in_data ^ pad_buf;
            out_last <= in_last;
            out_val  <= 1'b1;
        end else if (out_val && out_rdy) begin
            out_last <= 1'b0;
            out_val  <= 1'b0;
        end
    end

endmodule
